// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - time-division demultiplexer: rebuilds N-channel frames from a serial word stream
module tdm_demux #(
   parameter int W = 8,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   input  logic           in_sof,
   input  logic [W-1:0]   in_data,
   output logic [N*W-1:0] out_data,
   output logic           out_valid,
   output logic           out_err
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [N-1:0][W-1:0]   r_shadow;
   logic [N*W-1:0]        r_out_data;
   logic                  r_out_valid;
   logic                  r_out_err;

   logic                  w_last;
   logic [N*W-1:0]        w_frame;

   assign w_last = (r_cnt == CW'(N - 1));

   // Frame as it will look once the final word lands: shadow with the live word in the last slot
   always_comb begin
      w_frame                  = r_shadow;
      w_frame[(N-1)*W +: W]    = in_data;
   end

   // Frame-tracking FSM; slot counter, shadow buffer and all outputs are registered here
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_shadow    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         if (in_valid) begin
            case (r_state)
               IDLE: begin
                  // Words before the first start-of-frame are dropped without complaint
                  if (in_sof) begin
                     r_shadow[0] <= in_data;
                     r_cnt       <= CW'(1);
                     r_state     <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (in_sof) begin
                     // Short frame: abandon it and restart from this word
                     r_out_err   <= 1'b1;
                     r_shadow[0] <= in_data;
                     r_cnt       <= CW'(1);
                  end else begin
                     r_shadow[r_cnt] <= in_data;
                     if (w_last) begin
                        r_out_data  <= w_frame;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                     end else begin
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - table-driven self-checking bench for tdm_demux
module tb_tdm_demux;

   localparam int W = 8;
   localparam int N = 4;

   typedef struct {
      logic          rst_n;
      logic          valid;
      logic          sof;
      logic [W-1:0]  data;
      logic          exp_valid;
      logic          exp_err;
      logic [N*W-1:0] exp_data;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_sof = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic [N*W-1:0] out_data;
   logic           out_valid;
   logic           out_err;

   int total = 0;
   int bad   = 0;
   int step_no = 0;
   vec_t tbl[$];

   tdm_demux #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   // Queue one vector: inputs for a cycle and the outputs expected just after its rising edge
   task automatic add(input logic r, input logic v, input logic s, input logic [W-1:0] d,
                      input logic ev, input logic ee, input logic [N*W-1:0] ed);
      vec_t t;
      t.rst_n = r; t.valid = v; t.sof = s; t.data = d;
      t.exp_valid = ev; t.exp_err = ee; t.exp_data = ed;
      tbl.push_back(t);
   endtask

   // Drive one cycle of inputs, then check the registered outputs 1 time unit after the edge
   task automatic apply(input vec_t t, input string tag);
      @(negedge clk);
      rst_n    = t.rst_n;
      in_valid = t.valid;
      in_sof   = t.sof;
      in_data  = t.data;
      @(posedge clk);
      #1;
      step_no++;
      total++;
      if (out_valid !== t.exp_valid) begin
         bad++;
         $display("FAIL %s step%0d out_valid got=%b want=%b", tag, step_no, out_valid, t.exp_valid);
      end
      total++;
      if (out_err !== t.exp_err) begin
         bad++;
         $display("FAIL %s step%0d out_err got=%b want=%b", tag, step_no, out_err, t.exp_err);
      end
      total++;
      if (out_data !== t.exp_data) begin
         bad++;
         $display("FAIL %s step%0d out_data got=%h want=%h", tag, step_no, out_data, t.exp_data);
      end
   endtask

   initial begin
      vec_t g;
      logic [W-1:0] words [4];
      int pulses;

      // reset, including reset overriding a valid sof word
      add(0,0,0,8'h00, 0,0,32'h0);
      add(0,1,1,8'hFF, 0,0,32'h0);
      // basic frame
      add(1,1,1,8'h11, 0,0,32'h0);
      add(1,1,0,8'h22, 0,0,32'h0);
      add(1,1,0,8'h33, 0,0,32'h0);
      add(1,1,0,8'h44, 1,0,32'h44332211);
      add(1,0,0,8'h00, 0,0,32'h44332211);
      // short frame
      add(0,0,0,8'h00, 0,0,32'h0);
      add(1,1,1,8'hA1, 0,0,32'h0);
      add(1,1,0,8'hA2, 0,0,32'h0);
      add(1,1,1,8'hB1, 0,1,32'h0);
      add(1,1,0,8'hB2, 0,0,32'h0);
      add(1,1,0,8'hB3, 0,0,32'h0);
      add(1,1,0,8'hB4, 1,0,32'hB4B3B2B1);
      // garbage before sync
      add(0,0,0,8'h00, 0,0,32'h0);
      add(1,1,0,8'h55, 0,0,32'h0);
      add(1,1,0,8'h66, 0,0,32'h0);
      add(1,1,1,8'h01, 0,0,32'h0);
      add(1,1,0,8'h02, 0,0,32'h0);
      add(1,1,0,8'h03, 0,0,32'h0);
      add(1,1,0,8'h04, 1,0,32'h04030201);
      // back-to-back frames
      add(0,0,0,8'h00, 0,0,32'h0);
      add(1,1,1,8'h01, 0,0,32'h0);
      add(1,1,0,8'h02, 0,0,32'h0);
      add(1,1,0,8'h03, 0,0,32'h0);
      add(1,1,0,8'h04, 1,0,32'h04030201);
      add(1,1,1,8'h05, 0,0,32'h04030201);
      add(1,1,0,8'h06, 0,0,32'h04030201);
      add(1,1,0,8'h07, 0,0,32'h04030201);
      add(1,1,0,8'h08, 1,0,32'h08070605);
      // mid-frame reset, then a clean frame
      add(1,1,1,8'h11, 0,0,32'h08070605);
      add(1,1,0,8'h22, 0,0,32'h08070605);
      add(0,0,0,8'h00, 0,0,32'h0);
      add(1,1,0,8'h33, 0,0,32'h0);
      add(1,1,0,8'h44, 0,0,32'h0);
      add(1,1,1,8'h55, 0,0,32'h0);
      add(1,1,0,8'h66, 0,0,32'h0);
      add(1,1,0,8'h77, 0,0,32'h0);
      add(1,1,0,8'h88, 1,0,32'h88776655);

      foreach (tbl[i]) apply(tbl[i], "table");

      // gaps: three idle cycles after every word of a frame
      g = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      apply(g, "gap_reset");
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         g = '{1'b1, 1'b1, (k == 0), words[k], (k == 3), 1'b0,
               (k == 3) ? 32'h44332211 : 32'h0};
         apply(g, "gap_word");
         if (out_valid === 1'b1) pulses++;
         for (int j = 0; j < 3; j++) begin
            g = '{1'b1, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b0,
                  (k == 3) ? 32'h44332211 : 32'h0};
            apply(g, "gap_idle");
            if (out_valid === 1'b1) pulses++;
         end
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL gap_pulses got=%0d want=1", pulses);
      end

      // abort on the last slot: sof arriving where channel N-1 was due
      g = '{1'b1, 1'b1, 1'b1, 8'hC1, 1'b0, 1'b0, 32'h44332211}; apply(g, "late_abort");
      g = '{1'b1, 1'b1, 1'b0, 8'hC2, 1'b0, 1'b0, 32'h44332211}; apply(g, "late_abort");
      g = '{1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 32'h44332211}; apply(g, "late_abort");
      g = '{1'b1, 1'b1, 1'b1, 8'hD1, 1'b0, 1'b1, 32'h44332211}; apply(g, "late_abort");
      g = '{1'b1, 1'b1, 1'b0, 8'hD2, 1'b0, 1'b0, 32'h44332211}; apply(g, "late_abort");
      g = '{1'b1, 1'b1, 1'b0, 8'hD3, 1'b0, 1'b0, 32'h44332211}; apply(g, "late_abort");
      g = '{1'b1, 1'b1, 1'b0, 8'hD4, 1'b1, 1'b0, 32'hD4D3D2D1}; apply(g, "late_abort");
      g = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'hD4D3D2D1}; apply(g, "late_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
